// File: rtl/countdown_timer_p_if.sv
// Control and display bundle of the hh:mm:ss countdown timer.
// The master side (controller / bench) drives the requests and preset;
// the slave side (the timer) returns the BCD count and status flags.
interface countdown_timer_p_if;
   logic        en;
   logic        load;
   logic        start;
   logic        stop;
   logic [23:0] preset;
   logic [23:0] count;
   logic        running;
   logic        done;
   logic        alarm;
   logic        blink;

   modport master (
      output en, load, start, stop, preset,
      input  count, running, done, alarm, blink
   );

   modport slave (
      input  en, load, start, stop, preset,
      output count, running, done, alarm, blink
   );
endinterface

// File: rtl/countdown_timer_p.sv
// hh:mm:ss BCD countdown timer with an internal tick prescaler, start/pause
// control, clamped preset load, and either a timed alarm or auto-reload on
// expiry. Count packing is {hrs1,hrs0,min1,min0,sec1,sec0}.
module countdown_timer_p #(
   parameter int TICK_DIV    = 100_000_000,
   parameter int ALARM_TICKS = 10,
   parameter int AUTO_RELOAD = 0
) (
   input logic              clk,
   input logic              rst,
   countdown_timer_p_if.slave tmr
);

   localparam int PSC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int ALM_W = $clog2(ALARM_TICKS + 1);
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);
   localparam logic [PSC_W-1:0] PSC_HALF = PSC_W'(TICK_DIV / 2);
   localparam logic [ALM_W-1:0] ALM_LOAD = ALM_W'(ALARM_TICKS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

   state_t           state_q, state_d;
   logic [23:0]      count_q, count_d;
   logic [23:0]      reload_q, reload_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic [ALM_W-1:0] alm_q, alm_d;
   logic             done_q, done_d;
   logic             running_q, running_d;
   logic             alarm_q, alarm_d;
   logic             blink_q, blink_d;
   logic             tick;

   // Minutes/seconds tens digits saturate at 5, every other digit at 9.
   function automatic logic [23:0] clamp_bcd(input logic [23:0] p);
      logic [23:0] r;
      for (int i = 0; i < 6; i++) begin
         if (i == 1 || i == 3)
            r[i*4 +: 4] = (p[i*4 +: 4] > 4'd5) ? 4'd5 : p[i*4 +: 4];
         else
            r[i*4 +: 4] = (p[i*4 +: 4] > 4'd9) ? 4'd9 : p[i*4 +: 4];
      end
      return r;
   endfunction

   // One-second BCD decrement; a zero digit wraps to its maximum and borrows
   // from the next digit up. Never called with a zero count.
   function automatic logic [23:0] dec_bcd(input logic [23:0] c);
      logic [23:0] r;
      logic        borrow;
      r      = c;
      borrow = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (borrow) begin
            if (r[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      if (borrow) r[23:20] = r[23:20] - 4'd1;
      return r;
   endfunction

   assign tick = (psc_q == PSC_LAST);

   // Next-state logic: load outranks stop, stop outranks start; en gates all but load.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      psc_d    = psc_q;
      alm_d    = alm_q;
      done_d   = 1'b0;

      if (tmr.load && state_q != S_RUN) begin
         count_d  = clamp_bcd(tmr.preset);
         reload_d = clamp_bcd(tmr.preset);
         psc_d    = '0;
         state_d  = S_IDLE;
      end else if (tmr.en) begin
         case (state_q)
            S_IDLE: begin
               if (tmr.start && !tmr.stop && count_q != 24'h0) begin
                  state_d = S_RUN;
                  psc_d   = '0;
               end
            end
            S_RUN: begin
               psc_d = tick ? '0 : psc_q + PSC_W'(1);
               if (tick) begin
                  if (count_q == 24'h000001) begin
                     done_d = 1'b1;
                     if (AUTO_RELOAD != 0) begin
                        count_d = reload_q;
                     end else begin
                        count_d = 24'h0;
                        state_d = S_ALARM;
                        alm_d   = ALM_LOAD;
                     end
                  end else begin
                     count_d = dec_bcd(count_q);
                  end
               end
               // A tick coinciding with stop is still taken, so no second is lost.
               if (tmr.stop && state_d == S_RUN) state_d = S_PAUSE;
            end
            S_PAUSE: begin
               if (tmr.start && !tmr.stop) state_d = S_RUN;
            end
            S_ALARM: begin
               psc_d = tick ? '0 : psc_q + PSC_W'(1);
               if (tick) begin
                  alm_d = alm_q - ALM_W'(1);
                  if (alm_q == ALM_W'(1)) state_d = S_IDLE;
               end
               if (tmr.start || tmr.stop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      running_d = (state_d == S_RUN);
      alarm_d   = (state_d == S_ALARM);
      blink_d   = alarm_d && (psc_d < PSC_HALF);
   end

   // State, datapath and registered outputs with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         psc_q     <= '0;
         alm_q     <= '0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
         alarm_q   <= 1'b0;
         blink_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         psc_q     <= psc_d;
         alm_q     <= alm_d;
         done_q    <= done_d;
         running_q <= running_d;
         alarm_q   <= alarm_d;
         blink_q   <= blink_d;
      end
   end

   assign tmr.count   = count_q;
   assign tmr.running = running_q;
   assign tmr.done    = done_q;
   assign tmr.alarm   = alarm_q;
   assign tmr.blink   = blink_q;

endmodule

// File: tb/tb_countdown_timer_p.sv
// Bench for countdown_timer_p: two instances (alarm mode and auto-reload mode)
// share one stimulus stream and are compared every cycle against a model that
// keeps the remaining time as a plain number of seconds.
module tb_countdown_timer_p;

   localparam int TD = 4;
   localparam int AT = 3;

   typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mode_t;

   logic        clk = 1'b0;
   logic        rst_s = 1'b0;
   logic        en_s = 1'b1;
   logic        load_s = 1'b0;
   logic        start_s = 1'b0;
   logic        stop_s = 1'b0;
   logic [23:0] preset_s = 24'h0;

   int n_checks = 0;
   int n_errors = 0;

   int    m_sec  [2];
   int    m_rel  [2];
   int    m_ph   [2];
   int    m_alm  [2];
   mode_t m_mode [2];
   bit    m_done [2];

   countdown_timer_p_if ifa ();
   countdown_timer_p_if ifb ();

   assign ifa.en = en_s;     assign ifb.en = en_s;
   assign ifa.load = load_s; assign ifb.load = load_s;
   assign ifa.start = start_s; assign ifb.start = start_s;
   assign ifa.stop = stop_s; assign ifb.stop = stop_s;
   assign ifa.preset = preset_s; assign ifb.preset = preset_s;

   countdown_timer_p #(.TICK_DIV(TD), .ALARM_TICKS(AT), .AUTO_RELOAD(0)) dut_a (
      .clk (clk),
      .rst (rst_s),
      .tmr (ifa.slave)
   );

   countdown_timer_p #(.TICK_DIV(TD), .ALARM_TICKS(AT), .AUTO_RELOAD(1)) dut_b (
      .clk (clk),
      .rst (rst_s),
      .tmr (ifb.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Preset digits clamped and converted to a total number of seconds.
   function automatic int clamp_sec(input logic [23:0] p);
      int d [6];
      for (int k = 0; k < 6; k++) begin
         d[k] = int'(p[k*4 +: 4]);
         if (k == 1 || k == 3) begin
            if (d[k] > 5) d[k] = 5;
         end else begin
            if (d[k] > 9) d[k] = 9;
         end
      end
      return (d[5]*10 + d[4])*3600 + (d[3]*10 + d[2])*60 + d[1]*10 + d[0];
   endfunction

   function automatic logic [23:0] to_bcd(input int s);
      int h, m, x;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h/10), 4'(h%10), 4'(m/10), 4'(m%10), 4'(x/10), 4'(x%10)};
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_sec[u] = 0; m_rel[u] = 0; m_ph[u] = 0; m_alm[u] = 0;
         m_mode[u] = M_IDLE; m_done[u] = 1'b0;
      end
   endtask

   task automatic model_step(input int u);
      m_done[u] = 1'b0;
      if (load_s && m_mode[u] != M_RUN) begin
         m_sec[u]  = clamp_sec(preset_s);
         m_rel[u]  = m_sec[u];
         m_mode[u] = M_IDLE;
         m_ph[u]   = 0;
      end else if (en_s) begin
         case (m_mode[u])
            M_IDLE: if (start_s && !stop_s && m_sec[u] != 0) begin
               m_mode[u] = M_RUN;
               m_ph[u]   = 0;
            end
            M_RUN: begin
               m_ph[u]++;
               if (m_ph[u] == TD) begin
                  m_ph[u] = 0;
                  m_sec[u]--;
                  if (m_sec[u] == 0) begin
                     m_done[u] = 1'b1;
                     if (u == 1) m_sec[u] = m_rel[u];
                     else begin
                        m_mode[u] = M_ALARM;
                        m_alm[u]  = AT * TD;
                     end
                  end
               end
               if (stop_s && m_mode[u] == M_RUN) m_mode[u] = M_PAUSE;
            end
            M_PAUSE: if (start_s && !stop_s) m_mode[u] = M_RUN;
            M_ALARM: begin
               m_ph[u] = (m_ph[u] + 1) % TD;
               m_alm[u]--;
               if (m_alm[u] == 0 || start_s || stop_s) m_mode[u] = M_IDLE;
            end
            default: m_mode[u] = M_IDLE;
         endcase
      end
   endtask

   task automatic compare_unit(input int u);
      logic [23:0] c;
      logic [3:0]  f, ef;
      if (u == 0) begin
         c = ifa.count; f = {ifa.running, ifa.done, ifa.alarm, ifa.blink};
      end else begin
         c = ifb.count; f = {ifb.running, ifb.done, ifb.alarm, ifb.blink};
      end
      ef = {m_mode[u] == M_RUN, m_done[u], m_mode[u] == M_ALARM,
            (m_mode[u] == M_ALARM) && (m_ph[u] < TD/2)};
      check($sformatf("count_u%0d", u), {8'h0, c}, {8'h0, to_bcd(m_sec[u])});
      check($sformatf("run_done_alarm_blink_u%0d", u), {28'h0, f}, {28'h0, ef});
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_s) model_reset();
      else for (int u = 0; u < 2; u++) model_step(u);
      @(negedge clk);
      for (int u = 0; u < 2; u++) compare_unit(u);
   endtask

   task automatic cyc(input bit l, input bit sa, input bit so, input logic [23:0] p);
      load_s = l; start_s = sa; stop_s = so; preset_s = p;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, preset_s);
   endtask

   // Park both instances (pause or acknowledge) and then load a preset.
   task automatic ld(input logic [23:0] p);
      cyc(1'b0, 1'b0, 1'b1, preset_s);
      cyc(1'b1, 1'b0, 1'b0, p);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 60 && !ifa.done; i++) idle(1);
      check(tag, {31'h0, ifa.done}, 32'h1);
   endtask

   initial begin
      int cnt;
      model_reset();
      #1 rst_s = 1'b1;
      step();
      step();
      rst_s = 1'b0;

      // Clamped load
      cyc(1'b1, 1'b0, 1'b0, 24'h9F7A6B);
      check("clamp", {8'h0, ifa.count}, 32'h995959);
      idle(1);

      // Borrow chain over a full hour
      ld(24'h010000);
      cyc(1'b0, 1'b1, 1'b0, preset_s);
      idle(TD);
      check("borrow_first", {8'h0, ifa.count}, 32'h005959);
      idle(3599 * TD);
      check("borrow_done", {31'h0, ifa.done}, 32'h1);
      check("borrow_zero", {8'h0, ifa.count}, 32'h0);

      // Pause and resume without losing the partial second
      ld(24'h000003);
      cyc(1'b0, 1'b1, 1'b0, preset_s);
      idle(1);
      cyc(1'b0, 1'b0, 1'b1, preset_s);
      idle(20);
      cyc(1'b0, 1'b1, 1'b0, preset_s);
      idle(1);
      check("resume_hold", {8'h0, ifa.count}, 32'h000003);
      idle(1);
      check("resume_dec", {8'h0, ifa.count}, 32'h000002);

      // Alarm runs its full length
      wait_done("alarm_done_seen");
      cnt = ifa.alarm ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         if (ifa.alarm) cnt++;
      end
      check("alarm_len", cnt, AT * TD);

      // Alarm acknowledged by stop in its fifth cycle
      ld(24'h000001);
      cyc(1'b0, 1'b1, 1'b0, preset_s);
      wait_done("ack_done_seen");
      idle(3);
      check("ack_before", {31'h0, ifa.alarm}, 32'h1);
      cyc(1'b0, 1'b0, 1'b1, preset_s);
      check("ack_after", {31'h0, ifa.alarm}, 32'h0);

      // Auto-reload instance: done every 2*TD cycles, never alarms
      ld(24'h000002);
      cyc(1'b0, 1'b1, 1'b0, preset_s);
      cnt = 0;
      for (int i = 0; i < 8 * TD; i++) begin
         idle(1);
         if (ifb.done) cnt++;
         if (ifb.alarm) cnt += 100;
      end
      check("reload_dones", cnt, 4);

      // Start with a zero count is ignored
      ld(24'h000000);
      cyc(1'b0, 1'b1, 1'b0, preset_s);
      check("zero_start", {31'h0, ifa.running}, 32'h0);

      // load + stop + start together while paused
      ld(24'h000005);
      cyc(1'b0, 1'b1, 1'b0, preset_s);
      idle(2);
      cyc(1'b0, 1'b0, 1'b1, preset_s);
      cyc(1'b1, 1'b1, 1'b1, 24'h000007);
      check("multi_req_run", {31'h0, ifa.running}, 32'h0);
      check("multi_req_cnt", {8'h0, ifa.count}, 32'h000007);
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         en_s = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 3) == 0) preset_s = 24'($urandom);
         else preset_s = {16'h0, 8'($urandom)};
         if ($urandom_range(0, 3) == 0) preset_s = {20'h0, 4'($urandom_range(0, 3))};
         cyc($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 19) == 0, preset_s);
      end
      en_s = 1'b1;

      // Asynchronous reset in the middle of a run
      ld(24'h000005);
      cyc(1'b0, 1'b1, 1'b0, preset_s);
      idle(6);
      check("pre_rst_run", {31'h0, ifa.running}, 32'h1);
      #2 rst_s = 1'b1;
      #1;
      check("rst_a_count", {8'h0, ifa.count}, 32'h0);
      check("rst_a_flags", {28'h0, ifa.running, ifa.done, ifa.alarm, ifa.blink}, 32'h0);
      check("rst_b_count", {8'h0, ifb.count}, 32'h0);
      check("rst_b_flags", {28'h0, ifb.running, ifb.done, ifb.alarm, ifb.blink}, 32'h0);
      model_reset();
      step();
      rst_s = 1'b0;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
